matmul_sequencer: RTL and testbench

- Sequences one 2x2 matrix-multiply job through the TPU datapath: weight-memory load, unified-buffer input load, systolic streaming, drain, accumulator write-back and optional off-chip dispatch.
- Takes over the load_weight/load_input/valid/store/ext/base_address strobes that the control unit drives today.
- Sits between the instruction decode, which issues jobs, and the weight memory, unified buffer, input setup, mmu and accumulators.

---
 rtl/tpu_pkg.sv | 53 +++++
 rtl/seq_phase_counter.sv | 25 ++
 rtl/matmul_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and default constants for the matmul job sequencer.
package tpu_pkg;

  localparam int DEF_ADDR_W         = 5;
  localparam int DEF_STREAM_CYCLES  = 3;   // 2*dim-1 for the staggered 2x2 feed
  localparam int DEF_DRAIN_CYCLES   = 2;
  localparam int DEF_EXT_CYCLES     = 4;   // one result byte per cycle on uo_out
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_W,
    LOAD_IN,
    STREAM,
    DRAIN,
    WAIT_ACC,
    STORE,
    EXT,
    DONE
  } seq_state_t;

  // Single-bit outputs of the sequencer, registered together.
  typedef struct packed {
    logic cmd_ready;
    logic load_weight;
    logic load_input;
    logic valid;
    logic store;
    logic ext;
    logic busy;
    logic done;
  } seq_strobes_t;

  // Strobe pattern that belongs to a state; at most one datapath strobe is set.
  function automatic seq_strobes_t decode_strobes(input seq_state_t s);
    seq_strobes_t o;
    o             = '0;
    o.cmd_ready   = (s == IDLE);
    o.load_weight = (s == LOAD_W);
    o.load_input  = (s == LOAD_IN);
    o.valid       = (s == STREAM) || (s == DRAIN);
    o.store       = (s == STORE);
    o.ext         = (s == EXT);
    o.busy        = (s != IDLE);
    o.done        = (s == DONE);
    return o;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_phase_counter.sv
// Loadable down-counter that flags the last cycle of a multi-cycle phase.
// Loading N makes `last` rise in the N-th cycle after the load edge.
module seq_phase_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             last
);

  logic [CNT_W-1:0] count;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset)            count <= '0;
    else if (load)        count <= load_value;
    else if (count != '0) count <= count - 1'b1;
  end

  assign last = (count == CNT_W'(1));

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one 2x2 matmul job: weight load, input load, systolic stream,
// drain, accumulator wait, store and optional off-chip dispatch.
// Optional watchdog on WAIT_ACC (adds the err port): define MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer
  import tpu_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int STREAM_CYCLES  = DEF_STREAM_CYCLES,
  parameter int DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
  parameter int EXT_CYCLES     = DEF_EXT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_w_addr,
  input  logic [ADDR_W-1:0] cmd_in_addr,
  input  logic [ADDR_W-1:0] cmd_out_addr,
  input  logic              cmd_ext,
  input  logic              acc1_full,
  input  logic              acc2_full,
  output logic              load_weight,
  output logic              load_input,
  output logic              valid,
  output logic              store,
  output logic              ext,
  output logic [ADDR_W-1:0] base_address,
  output logic              busy,
  output logic              done
`ifdef MATMUL_SEQ_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam int MAX_PHASE = max_of(max_of(STREAM_CYCLES, DRAIN_CYCLES),
                                    max_of(EXT_CYCLES, TIMEOUT_CYCLES));
  localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

  seq_state_t        state, state_next;
  seq_strobes_t      strb_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] in_addr_q, out_addr_q;
  logic              ext_q, f1, f2;
  logic              accept, flags_set;
  logic              cnt_load, cnt_last;
  logic [CNT_W-1:0]  cnt_value;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  logic              err_set;
`endif

  assign accept    = cmd_valid && cmd_ready;
  assign flags_set = (f1 || acc1_full) && (f2 || acc2_full);

  seq_phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .last       (cnt_last)
  );

  // Next-state, phase-counter load and next base address.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    addr_d     = '0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    err_set    = 1'b0;
`endif
    unique case (state)
      IDLE:    if (accept) state_next = LOAD_W;
      LOAD_W:  state_next = LOAD_IN;
      LOAD_IN: begin
        state_next = STREAM;
        cnt_load   = 1'b1;
        cnt_value  = CNT_W'(STREAM_CYCLES);
      end
      STREAM: if (cnt_last) begin
        state_next = DRAIN;
        cnt_load   = 1'b1;
        cnt_value  = CNT_W'(DRAIN_CYCLES);
      end
      DRAIN: if (cnt_last) begin
        state_next = WAIT_ACC;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        cnt_load   = 1'b1;
        cnt_value  = CNT_W'(TIMEOUT_CYCLES);
`endif
      end
      WAIT_ACC: begin
        if (flags_set) state_next = STORE;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        else if (cnt_last) begin
          state_next = DONE;
          err_set    = 1'b1;
        end
`endif
      end
      STORE: begin
        if (ext_q) begin
          state_next = EXT;
          cnt_load   = 1'b1;
          cnt_value  = CNT_W'(EXT_CYCLES);
        end else begin
          state_next = DONE;
        end
      end
      EXT:     if (cnt_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // The weight address is taken straight from the command on the accept edge.
    case (state_next)
      LOAD_W:          addr_d = cmd_w_addr;
      LOAD_IN, STREAM: addr_d = in_addr_q;
      STORE, EXT:      addr_d = out_addr_q;
      default:         addr_d = '0;
    endcase
  end

  // State and registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      strb_q       <= decode_strobes(IDLE);
      base_address <= '0;
    end else begin
      state        <= state_next;
      strb_q       <= decode_strobes(state_next);
      base_address <= addr_d;
    end
  end

  // Job fields captured on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_addr_q  <= '0;
      out_addr_q <= '0;
      ext_q      <= 1'b0;
    end else if (accept) begin
      in_addr_q  <= cmd_in_addr;
      out_addr_q <= cmd_out_addr;
      ext_q      <= cmd_ext;
    end
  end

  // Sticky accumulator-full flags: cleared on accept, collected from STREAM onward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f1 <= 1'b0;
      f2 <= 1'b0;
    end else if (accept) begin
      f1 <= 1'b0;
      f2 <= 1'b0;
    end else if (state inside {STREAM, DRAIN, WAIT_ACC}) begin
      f1 <= f1 || acc1_full;
      f2 <= f2 || acc2_full;
    end
  end

`ifdef MATMUL_SEQ_TIMEOUT_EN
  // Timeout flag: set on watchdog expiry, held until the next accepted job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (accept)  err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`endif

  assign cmd_ready   = strb_q.cmd_ready;
  assign load_weight = strb_q.load_weight;
  assign load_input  = strb_q.load_input;
  assign valid       = strb_q.valid;
  assign store       = strb_q.store;
  assign ext         = strb_q.ext;
  assign busy        = strb_q.busy;
  assign done        = strb_q.done;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed self-checking bench for matmul_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_matmul_sequencer;

  localparam int AW = 5;
  // Expected output pattern bits: {load_weight,load_input,valid,store,ext,busy,done,cmd_ready}
  localparam logic [7:0] P_LW   = 8'b1000_0100;
  localparam logic [7:0] P_LI   = 8'b0100_0100;
  localparam logic [7:0] P_V    = 8'b0010_0100;
  localparam logic [7:0] P_ST   = 8'b0001_0100;
  localparam logic [7:0] P_EX   = 8'b0000_1100;
  localparam logic [7:0] P_WAIT = 8'b0000_0100;
  localparam logic [7:0] P_DONE = 8'b0000_0110;
  localparam logic [7:0] P_IDLE = 8'b0000_0001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ext = 1'b0, acc1_full = 1'b0, acc2_full = 1'b0;
  logic [AW-1:0] cmd_w_addr = '0, cmd_in_addr = '0, cmd_out_addr = '0;
  logic          cmd_ready, load_weight, load_input, valid, store, ext, busy, done;
  logic [AW-1:0] base_address;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  logic          err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]    exp_v [64];
  logic [AW-1:0] exp_a [64];
  bit            exp_care [64];
  int            exp_n;
  logic [7:0]    tr_v [64];
  logic [AW-1:0] tr_a [64];
  logic          tr_err [64];
  bit            a1_s [64], a2_s [64], cv_s [64];

  matmul_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_w_addr   (cmd_w_addr),
    .cmd_in_addr  (cmd_in_addr),
    .cmd_out_addr (cmd_out_addr),
    .cmd_ext      (cmd_ext),
    .acc1_full    (acc1_full),
    .acc2_full    (acc2_full),
    .load_weight  (load_weight),
    .load_input   (load_input),
    .valid        (valid),
    .store        (store),
    .ext          (ext),
    .base_address (base_address),
    .busy         (busy),
    .done         (done)
`ifdef MATMUL_SEQ_TIMEOUT_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {load_weight, load_input, valid, store, ext, busy, done, cmd_ready};
  endfunction

  task automatic clear_plan();
    exp_n = 1;
    for (int i = 0; i < 64; i++) begin
      a1_s[i] = 1'b0; a2_s[i] = 1'b0; cv_s[i] = 1'b0; exp_care[i] = 1'b0;
    end
  endtask

  task automatic add_phase(input logic [7:0] sig, input int len, input logic [AW-1:0] a, input bit care);
    for (int i = 0; i < len; i++) begin
      exp_v[exp_n] = sig; exp_a[exp_n] = a; exp_care[exp_n] = care;
      exp_n++;
    end
  endtask

  // Present a job for one edge; returns at the falling edge of cycle 1 after accept.
  task automatic start_job(input logic [AW-1:0] w, input logic [AW-1:0] i, input logic [AW-1:0] o, input logic e);
    cmd_w_addr = w; cmd_in_addr = i; cmd_out_addr = o; cmd_ext = e; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_w_addr = '0; cmd_in_addr = '0; cmd_out_addr = '0; cmd_ext = 1'b0;
  endtask

  // Record n cycles of outputs while replaying the acc-full / stray-command schedule.
  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      tr_v[k] = obs();
      tr_a[k] = base_address;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      tr_err[k] = err;
`else
      tr_err[k] = 1'b0;
`endif
      acc1_full = a1_s[k];
      acc2_full = a2_s[k];
      cmd_valid = cv_s[k];
      cmd_w_addr   = cv_s[k] ? 5'd7  : 5'd0;
      cmd_in_addr  = cv_s[k] ? 5'd1  : 5'd0;
      cmd_out_addr = cv_s[k] ? 5'd30 : 5'd0;
      cmd_ext      = cv_s[k];
      @(negedge clk);
    end
    acc1_full = 1'b0; acc2_full = 1'b0; cmd_valid = 1'b0; cmd_ext = 1'b0;
    cmd_w_addr = '0; cmd_in_addr = '0; cmd_out_addr = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if (obs() !== P_IDLE || base_address !== '0)
      $display("FAIL reset_hold: got sig=%b addr=%0d, want sig=%b addr=0", obs(), base_address, P_IDLE);
    else pass_cnt++;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++;
      if (obs() !== P_IDLE || base_address !== '0)
        $display("FAIL reset_idle cyc%0d: got sig=%b addr=%0d, want sig=%b addr=0", k, obs(), base_address, P_IDLE);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic_job();
    int done_at;
    clear_plan();
    a1_s[6] = 1'b1; a1_s[7] = 1'b1; a2_s[6] = 1'b1; a2_s[7] = 1'b1;
    add_phase(P_LW, 1, 5'd3, 1'b1);  add_phase(P_LI, 1, 5'd8, 1'b1);
    add_phase(P_V, 3, 5'd8, 1'b1);   add_phase(P_V, 2, 5'd0, 1'b0);
    add_phase(P_WAIT, 1, 5'd0, 1'b0); add_phase(P_ST, 1, 5'd16, 1'b1);
    add_phase(P_DONE, 1, 5'd0, 1'b0); add_phase(P_IDLE, 2, 5'd0, 1'b0);
    start_job(5'd3, 5'd8, 5'd16, 1'b0);
    capture(exp_n - 1);
    done_at = 0;
    for (int k = 1; k < exp_n; k++) begin
      if (tr_v[k][1] === 1'b1 && done_at == 0) done_at = k;
      total_cnt++;
      if (tr_v[k] !== exp_v[k] || (exp_care[k] && tr_a[k] !== exp_a[k]))
        $display("FAIL basic cyc%0d: got sig=%b addr=%0d, want sig=%b addr=%0d", k, tr_v[k], tr_a[k], exp_v[k], exp_a[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (done_at !== 10) $display("FAIL basic_latency: got done at cycle %0d, want 10", done_at);
    else pass_cnt++;
  endtask

  task automatic test_ext_job();
    clear_plan();
    a1_s[6] = 1'b1; a1_s[7] = 1'b1; a2_s[6] = 1'b1; a2_s[7] = 1'b1;
    add_phase(P_LW, 1, 5'd3, 1'b1);  add_phase(P_LI, 1, 5'd8, 1'b1);
    add_phase(P_V, 3, 5'd8, 1'b1);   add_phase(P_V, 2, 5'd0, 1'b0);
    add_phase(P_WAIT, 1, 5'd0, 1'b0); add_phase(P_ST, 1, 5'd16, 1'b1);
    add_phase(P_EX, 4, 5'd16, 1'b1); add_phase(P_DONE, 1, 5'd0, 1'b0);
    add_phase(P_IDLE, 2, 5'd0, 1'b0);
    start_job(5'd3, 5'd8, 5'd16, 1'b1);
    capture(exp_n - 1);
    for (int k = 1; k < exp_n; k++) begin
      total_cnt++;
      if (tr_v[k] !== exp_v[k] || (exp_care[k] && tr_a[k] !== exp_a[k]))
        $display("FAIL ext cyc%0d: got sig=%b addr=%0d, want sig=%b addr=%0d", k, tr_v[k], tr_a[k], exp_v[k], exp_a[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (tr_v[14] !== P_DONE) $display("FAIL ext_latency: got sig=%b at cycle 14, want %b", tr_v[14], P_DONE);
    else pass_cnt++;
  endtask

  // Single-cycle acc pulses late in WAIT_ACC plus a stray command mid-job.
  task automatic test_staggered_full();
    clear_plan();
    a1_s[10] = 1'b1; a2_s[13] = 1'b1; cv_s[5] = 1'b1;
    add_phase(P_LW, 1, 5'd2, 1'b1);  add_phase(P_LI, 1, 5'd9, 1'b1);
    add_phase(P_V, 3, 5'd9, 1'b1);   add_phase(P_V, 2, 5'd0, 1'b0);
    add_phase(P_WAIT, 6, 5'd0, 1'b0); add_phase(P_ST, 1, 5'd20, 1'b1);
    add_phase(P_DONE, 1, 5'd0, 1'b0); add_phase(P_IDLE, 2, 5'd0, 1'b0);
    start_job(5'd2, 5'd9, 5'd20, 1'b0);
    capture(exp_n - 1);
    for (int k = 1; k < exp_n; k++) begin
      total_cnt++;
      if (tr_v[k] !== exp_v[k] || (exp_care[k] && tr_a[k] !== exp_a[k]))
        $display("FAIL staggered cyc%0d: got sig=%b addr=%0d, want sig=%b addr=%0d", k, tr_v[k], tr_a[k], exp_v[k], exp_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_stream();
    int done_seen;
    start_job(5'd4, 5'd12, 5'd24, 1'b0);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (valid !== 1'b1) $display("FAIL abort_pre: got valid=%b in 2nd stream cycle, want 1", valid);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (obs() !== P_IDLE || base_address !== '0)
      $display("FAIL abort_async: got sig=%b addr=%0d, want sig=%b addr=0", obs(), base_address, P_IDLE);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL abort_quiet: got %0d cycles with done/busy, want 0", done_seen);
    else pass_cnt++;
    clear_plan();
    a1_s[6] = 1'b1; a2_s[7] = 1'b1;
    add_phase(P_LW, 1, 5'd1, 1'b1);  add_phase(P_LI, 1, 5'd6, 1'b1);
    add_phase(P_V, 3, 5'd6, 1'b1);   add_phase(P_V, 2, 5'd0, 1'b0);
    add_phase(P_WAIT, 1, 5'd0, 1'b0); add_phase(P_ST, 1, 5'd11, 1'b1);
    add_phase(P_DONE, 1, 5'd0, 1'b0); add_phase(P_IDLE, 1, 5'd0, 1'b0);
    start_job(5'd1, 5'd6, 5'd11, 1'b0);
    capture(exp_n - 1);
    for (int k = 1; k < exp_n; k++) begin
      total_cnt++;
      if (tr_v[k] !== exp_v[k] || (exp_care[k] && tr_a[k] !== exp_a[k]))
        $display("FAIL post_abort cyc%0d: got sig=%b addr=%0d, want sig=%b addr=%0d", k, tr_v[k], tr_a[k], exp_v[k], exp_a[k]);
      else pass_cnt++;
    end
  endtask

`ifdef MATMUL_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    clear_plan();
    add_phase(P_LW, 1, 5'd5, 1'b1);  add_phase(P_LI, 1, 5'd10, 1'b1);
    add_phase(P_V, 3, 5'd10, 1'b1);  add_phase(P_V, 2, 5'd0, 1'b0);
    add_phase(P_WAIT, 15, 5'd0, 1'b0); add_phase(P_DONE, 1, 5'd0, 1'b0);
    add_phase(P_IDLE, 2, 5'd0, 1'b0);
    start_job(5'd5, 5'd10, 5'd15, 1'b1);
    capture(exp_n - 1);
    for (int k = 1; k < exp_n; k++) begin
      total_cnt++;
      if (tr_v[k] !== exp_v[k] || (exp_care[k] && tr_a[k] !== exp_a[k]))
        $display("FAIL timeout cyc%0d: got sig=%b addr=%0d, want sig=%b addr=%0d", k, tr_v[k], tr_a[k], exp_v[k], exp_a[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (tr_err[22] !== 1'b0 || tr_err[23] !== 1'b1 || tr_err[25] !== 1'b1)
      $display("FAIL timeout_err: got err=%b/%b/%b at cycles 22/23/25, want 0/1/1", tr_err[22], tr_err[23], tr_err[25]);
    else pass_cnt++;
    clear_plan();
    a1_s[6] = 1'b1; a2_s[6] = 1'b1;
    start_job(5'd5, 5'd10, 5'd15, 1'b0);
    capture(11);
    total_cnt++;
    if (tr_err[1] !== 1'b0 || tr_v[10] !== P_DONE)
      $display("FAIL timeout_clear: got err=%b sig@10=%b, want err=0 sig=%b", tr_err[1], tr_v[10], P_DONE);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_basic_job();
    test_ext_job();
    test_staggered_full();
    test_reset_mid_stream();
`ifdef MATMUL_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
